// File: rtl/i2c_byte_master.sv
// I2C write-only byte master: drains a 9-bit FIFO (bit 8 = last-of-transaction)
// and emits START / bytes with ACK check / STOP on open-drain SCL/SDA.
module i2c_byte_master #(
    parameter int CLK_HZ = 12000000,
    parameter int I2C_HZ = 400000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       nack
);
    localparam int QRAW = CLK_HZ / (4 * I2C_HZ);
    localparam int QDIV = (QRAW < 1) ? 1 : QRAW;
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_ACK, S_NEXT, S_FLUSH, S_STOP, S_BUSFREE
    } state_t;

    state_t        state_q;
    logic [QW-1:0] qcnt_q;
    logic [1:0]    ph_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          last_q, ack_q;
    logic          scl_q, sda_q, busy_q, nack_q;
    logic          tick, pop_d;

    assign tick = busy_q && (qcnt_q == QW'(QDIV - 1));

    // Pop is combinational so the FIFO advances on the same edge the head is latched.
    assign pop_d = resetn && !fifo_empty &&
                   ((state_q == S_IDLE) ||
                    (tick && (state_q == S_NEXT || state_q == S_FLUSH)));

    assign fifo_pop = pop_d;
    assign scl_oe   = scl_q;
    assign sda_oe   = sda_q;
    assign busy     = busy_q;
    assign nack     = nack_q;

    // Line registers always hold the levels of the quarter currently in progress;
    // each tick advances the phase and loads the next quarter's levels.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            ph_q    <= 2'd0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            last_q  <= 1'b0;
            ack_q   <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            busy_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            nack_q <= 1'b0;
            if (busy_q) qcnt_q <= tick ? '0 : qcnt_q + 1'b1;
            else        qcnt_q <= '0;

            case (state_q)
                S_IDLE: if (pop_d) begin
                    sh_q    <= fifo_dout[7:0];
                    last_q  <= fifo_dout[8];
                    busy_q  <= 1'b1;
                    ph_q    <= 2'd0;
                    scl_q   <= 1'b0;
                    sda_q   <= 1'b0;
                    state_q <= S_START;
                end
                S_START: if (tick) begin
                    ph_q <= ph_q + 2'd1;
                    case (ph_q)
                        2'd0:    sda_q <= 1'b1;
                        2'd2:    scl_q <= 1'b1;
                        2'd3: begin
                            bit_q   <= 3'd7;
                            sda_q   <= ~sh_q[7];
                            state_q <= S_DATA;
                        end
                        default: ;
                    endcase
                end
                S_DATA: if (tick) begin
                    ph_q <= ph_q + 2'd1;
                    case (ph_q)
                        2'd0:    scl_q <= 1'b0;
                        2'd2:    scl_q <= 1'b1;
                        2'd3: begin
                            if (bit_q == 3'd0) begin
                                sda_q   <= 1'b0;
                                state_q <= S_ACK;
                            end else begin
                                bit_q <= bit_q - 3'd1;
                                sh_q  <= {sh_q[6:0], 1'b0};
                                sda_q <= ~sh_q[6];
                            end
                        end
                        default: ;
                    endcase
                end
                S_ACK: if (tick) begin
                    ph_q <= ph_q + 2'd1;
                    case (ph_q)
                        2'd0: scl_q <= 1'b0;
                        2'd2: begin
                            ack_q <= sda_in;
                            scl_q <= 1'b1;
                        end
                        2'd3: begin
                            // SCL stays low; SDA pulled low for STOP Q0 / NEXT / FLUSH alike.
                            sda_q  <= 1'b1;
                            nack_q <= ack_q;
                            if (ack_q && !last_q)   state_q <= S_FLUSH;
                            else if (ack_q || last_q) state_q <= S_STOP;
                            else                    state_q <= S_NEXT;
                        end
                        default: ;
                    endcase
                end
                S_NEXT: if (pop_d) begin
                    sh_q    <= fifo_dout[7:0];
                    last_q  <= fifo_dout[8];
                    bit_q   <= 3'd7;
                    ph_q    <= 2'd0;
                    sda_q   <= ~fifo_dout[7];
                    state_q <= S_DATA;
                end
                S_FLUSH: if (pop_d && fifo_dout[8]) begin
                    ph_q    <= 2'd0;
                    state_q <= S_STOP;
                end
                S_STOP: if (tick) begin
                    ph_q <= ph_q + 2'd1;
                    case (ph_q)
                        2'd0:    scl_q <= 1'b0;
                        2'd2:    sda_q <= 1'b0;
                        2'd3:    state_q <= S_BUSFREE;
                        default: ;
                    endcase
                end
                S_BUSFREE: if (tick) begin
                    ph_q <= ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: FIFO model, I2C bus decoder plus ACKing slave, and a
// transaction-level model of which bytes reach the bus.
module tb_i2c_byte_master;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] fifo_dout = 9'h0;
    logic       fifo_empty = 1'b1;
    logic       fifo_pop, scl_oe, sda_oe, sda_in, busy, nack;
    logic       slave_pull = 1'b0;

    i2c_byte_master #(.CLK_HZ(4000000), .I2C_HZ(1000000)) dut (
        .clk(clk), .resetn(resetn), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in),
        .busy(busy), .nack(nack)
    );

    always #5 clk = ~clk;
    assign sda_in = ~(sda_oe | slave_pull);

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus monitor + slave (owned by the negedge process) ----------------
    logic [7:0] obs_byte [0:255];
    int         busy_len [0:255];
    logic       ack_plan [0:255];   // 1 = slave NACKs that transmitted byte
    int n_plan = 0;                 // written by stimulus only
    int nobs = 0, nbusy = 0, busy_run = 0, nstart = 0, nstop = 0, nrise = 0;
    int nnack_cyc = 0, nbadpop = 0, ack_used = 0, nmiss = 0, cycn = 0, stop_cyc = 0, last_gap = 0;
    int nbits = 0;
    logic started = 1'b0, pop_seen = 1'b0, scl_p = 1'b1, sda_p = 1'b1;
    logic [7:0] shreg = 8'h0;

    always @(negedge clk) begin
        logic scl_n, sda_n;
        scl_n = ~scl_oe;
        sda_n = sda_in;
        cycn++;
        pop_seen = fifo_pop;
        if (fifo_pop && fifo_empty) nbadpop++;
        if (nack) nnack_cyc++;
        if (busy) busy_run++;
        else if (busy_run > 0) begin
            busy_len[nbusy] = busy_run;
            nbusy++;
            busy_run = 0;
        end
        if (!resetn) begin
            started = 1'b0;
            nbits = 0;
            slave_pull = 1'b0;
        end else if (scl_p && scl_n && sda_p && !sda_n) begin
            nstart++;
            if (nstop > 0) last_gap = cycn - stop_cyc;
            started = 1'b1;
            nbits = 0;
        end else if (scl_p && scl_n && !sda_p && sda_n) begin
            nstop++;
            stop_cyc = cycn;
            started = 1'b0;
            nbits = 0;
        end else if (!scl_p && scl_n) begin
            nrise++;
            if (started) begin
                if (nbits < 8) shreg = {shreg[6:0], sda_n};
                nbits++;
                if (nbits == 9) begin
                    obs_byte[nobs] = shreg;
                    nobs++;
                    nbits = 0;
                end
            end
        end else if (scl_p && !scl_n) begin
            if (started && nbits == 8) begin
                if (ack_used < n_plan) slave_pull = ~ack_plan[ack_used];
                else begin
                    slave_pull = 1'b1;
                    nmiss++;
                end
                ack_used++;
            end else slave_pull = 1'b0;
        end
        scl_p = scl_n;
        sda_p = ~(sda_oe | slave_pull);
    end

    // ---------------- FIFO model (owned by the stimulus thread) ----------------
    logic [8:0] fq [$];
    int npop = 0;

    function automatic void refresh();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 9'h0;
    endfunction

    function automatic void push(input logic [8:0] e);
        fq.push_back(e);
        refresh();
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (pop_seen && fq.size() != 0) begin
            void'(fq.pop_front());
            npop++;
        end
        refresh();
    endtask

    task automatic wait_idle(input string nm);
        int quiet = 0, t = 0;
        while (quiet < 3 && t < 4000) begin
            cyc();
            t++;
            if (!busy && fq.size() == 0) quiet++;
            else quiet = 0;
        end
        chk({nm, "_done"}, quiet >= 3, 1);
    endtask

    // ---------------- transaction-level model and checks ----------------
    logic [8:0] ent [$];
    logic       nk  [$];

    task automatic run_case(input string nm, input int gap);
        int   b_obs = nobs, b_start = nstart, b_stop = nstop, b_rise = nrise;
        int   b_nack = nnack_cyc, b_pop = npop, b_busy = nbusy, b_bad = nbadpop;
        int   b_used = ack_used, b_miss = nmiss;
        int   exp_bytes [$];
        int   exp_len [$];
        int   exp_nack = 0, exp_txn = 0, cnt = 0, plans = 0, badgap = 0, t = 0;
        logic dropping = 1'b0, nacked = 1'b0;
        // A NACK drops the rest of its transaction; the next one starts fresh.
        foreach (ent[i]) begin
            if (!dropping) begin
                exp_bytes.push_back(int'(ent[i][7:0]));
                ack_plan[n_plan] = nk[i];
                n_plan++;
                plans++;
                cnt++;
                if (nk[i]) begin
                    exp_nack++;
                    dropping = 1'b1;
                    nacked = 1'b1;
                end
            end
            if (ent[i][8]) begin
                exp_txn++;
                exp_len.push_back((cnt == 1 && !nacked) ? 48 : 0);
                dropping = 1'b0;
                nacked = 1'b0;
                cnt = 0;
            end
        end

        if (gap > 0) begin
            push(ent[0]);
            while (nobs == b_obs && t < 500) begin
                cyc();
                t++;
            end
            chk({nm, "_first_byte"}, nobs - b_obs, 1);
            repeat (3) cyc();
            for (int i = 0; i < gap; i++) begin
                cyc();
                if (!scl_oe || !busy) badgap++;
            end
            chk({nm, "_scl_low_gap"}, badgap, 0);
            for (int i = 1; i < ent.size(); i++) push(ent[i]);
        end else begin
            foreach (ent[i]) push(ent[i]);
        end
        wait_idle(nm);

        chk({nm, "_nbytes"}, nobs - b_obs, exp_bytes.size());
        foreach (exp_bytes[i])
            if (b_obs + i < nobs) chk({nm, "_byte"}, obs_byte[b_obs + i], exp_bytes[i]);
        chk({nm, "_starts"}, nstart - b_start, exp_txn);
        chk({nm, "_stops"}, nstop - b_stop, exp_txn);
        // Nine SCL pulses per byte on the wire plus the one inside each STOP.
        chk({nm, "_scl_rises"}, nrise - b_rise, 9 * exp_bytes.size() + exp_txn);
        chk({nm, "_nack_cycles"}, nnack_cyc - b_nack, exp_nack);
        chk({nm, "_pops"}, npop - b_pop, ent.size());
        chk({nm, "_fifo_left"}, fq.size(), 0);
        chk({nm, "_busy_windows"}, nbusy - b_busy, exp_txn);
        foreach (exp_len[k])
            if (exp_len[k] != 0 && b_busy + k < nbusy)
                chk({nm, "_busy_len"}, busy_len[b_busy + k], exp_len[k]);
        chk({nm, "_acks_asked"}, ack_used - b_used, plans);
        chk({nm, "_ack_unplanned"}, nmiss - b_miss, 0);
        chk({nm, "_pop_empty"}, nbadpop - b_bad, 0);
    endtask

    initial begin
        refresh();
        repeat (3) cyc();
        chk("rst_scl", scl_oe, 0);
        chk("rst_sda", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_nack", nack, 0);
        chk("rst_pop", fifo_pop, 0);

        // Reset landing in the middle of a byte releases the bus at once.
        resetn = 1'b1;
        push(9'h1A5);
        repeat (20) cyc();
        chk("mid_busy", busy, 1);
        chk("mid_scl_driven", scl_oe | sda_oe, 1);
        resetn = 1'b0;
        cyc();
        chk("mid_rst_scl", scl_oe, 0);
        chk("mid_rst_sda", sda_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pop", fifo_pop, 0);
        cyc();
        cyc();
        resetn = 1'b1;
        repeat (4) cyc();

        ent = {9'h178}; nk = {1'b0};
        run_case("single", 0);
        ent = {9'h078, 9'h000, 9'h1AF}; nk = {1'b0, 1'b0, 1'b0};
        run_case("three", 0);
        ent = {9'h078, 9'h100}; nk = {1'b0, 1'b0};
        run_case("gap", 20);
        ent = {9'h07A, 9'h011, 9'h122}; nk = {1'b1, 1'b0, 1'b0};
        run_case("nack_flush", 0);
        ent = {9'h13C, 9'h1C3}; nk = {1'b0, 1'b0};
        run_case("two_txn", 0);
        chk("two_txn_busfree", last_gap >= 4, 1);

        for (int r = 0; r < 6; r++) begin
            int ntx;
            ent = {};
            nk = {};
            ntx = $urandom_range(1, 3);
            for (int t = 0; t < ntx; t++) begin
                int nb;
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    ent.push_back({(b == nb - 1), d});
                    nk.push_back($urandom_range(0, 3) == 0);
                end
            end
            run_case("rnd", 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
